// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : uart_pkg
//  Purpose : Shared types, defaults and helpers for the UART transmit path.
//            - uart_tx_state_t : transmitter FSM state encoding
//            - DEFAULT_*       : default frame timing / payload width
//            - even_parity()   : XOR reduction used for the optional parity bit
//  Rev     : 1.0  initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 10;
    localparam int DEFAULT_DATA_BITS    = 8;

    // Widest payload the parity helper accepts; narrower payloads are
    // zero-extended by the caller, which leaves the XOR unchanged.
    localparam int PARITY_MAX_BITS      = 32;

    function automatic logic even_parity(input logic [PARITY_MAX_BITS-1:0] data);
        return ^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module  : uart_tx_bit_timer
//  Purpose : Modulo-COUNT_MAX counter with clear, enable and rollover flag.
//            Used twice by uart_tx: once as the per-bit cycle timer and once
//            as the data-bit index counter.
//  Ports   : clk_i       system clock, rising edge
//            n_rst_i     synchronous active-low reset
//            clr_i       force count to 0 (has priority over en_i)
//            en_i        advance the count by one this cycle
//            rollover_o  high while en_i is set and the count is at its last
//                        value; the count wraps to 0 on that edge
//  Rev     : 1.0  initial release
// ============================================================================
module uart_tx_bit_timer #(
    parameter int COUNT_MAX = 10
) (
    input  logic clk_i,
    input  logic n_rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic rollover_o
);

    localparam int            c_cw   = (COUNT_MAX > 1) ? $clog2(COUNT_MAX) : 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(COUNT_MAX - 1);

    logic [c_cw-1:0] count_q;
    logic [c_cw-1:0] count_d;
    logic            w_at_last;

    assign w_at_last  = (count_q == c_last);
    assign rollover_o = en_i & w_at_last;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = w_at_last ? '0 : (count_q + c_cw'(1));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!n_rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module  : uart_tx
//  Purpose : Asynchronous serial transmitter. Frame = 1 start bit (0),
//            DATA_BITS data bits LSB first, optional even parity bit,
//            1 stop bit (1). Every non-idle bit lasts CLKS_PER_BIT cycles.
//  Ports   : clk_i         system clock, rising edge
//            n_rst_i       synchronous active-low reset
//            tx_data_i     payload, captured when tx_start_i is accepted
//            tx_start_i    request strobe, accepted only while idle
//            tx_busy_o     high while a frame is in progress
//            tx_done_o     one-cycle pulse once the stop bit completes
//            serial_out_o  serial line, idle high, registered
//  Config  : UART_TX_PARITY_EN  when defined, an even-parity bit is inserted
//            between the last data bit and the stop bit.
//  Rev     : 1.0  initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
    input  logic                 clk_i,
    input  logic                 n_rst_i,
    input  logic [DATA_BITS-1:0] tx_data_i,
    input  logic                 tx_start_i,
    output logic                 tx_busy_o,
    output logic                 tx_done_o,
    output logic                 serial_out_o
);

    uart_tx_state_t       state_q,  state_d;
    logic [DATA_BITS-1:0] shreg_q,  shreg_d;
    logic                 serial_q, serial_d;
    logic                 busy_q,   busy_d;
    logic                 done_q,   done_d;

    logic w_bit_tick;   // last cycle of the current bit period
    logic w_last_bit;   // last cycle of the final data bit
    logic w_timer_clr;
    logic w_timer_en;
    logic w_idx_clr;
    logic w_idx_en;

    // The cycle timer free-runs in every non-idle state and sits at 0 in
    // IDLE, so the first bit after acceptance gets its full period.
    assign w_timer_clr = (state_q == IDLE);
    assign w_timer_en  = (state_q != IDLE);

    uart_tx_bit_timer #(
        .COUNT_MAX (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk_i      (clk_i),
        .n_rst_i    (n_rst_i),
        .clr_i      (w_timer_clr),
        .en_i       (w_timer_en),
        .rollover_o (w_bit_tick)
    );

    // The index counter only steps at bit boundaries inside DATA, so its
    // rollover marks the end of the final data bit.
    assign w_idx_clr = (state_q != DATA);
    assign w_idx_en  = (state_q == DATA) & w_bit_tick;

    uart_tx_bit_timer #(
        .COUNT_MAX (DATA_BITS)
    ) u_bit_index (
        .clk_i      (clk_i),
        .n_rst_i    (n_rst_i),
        .clr_i      (w_idx_clr),
        .en_i       (w_idx_en),
        .rollover_o (w_last_bit)
    );

`ifdef UART_TX_PARITY_EN
    // Parity is computed once from the accepted byte, since the shift
    // register has been consumed by the time the parity bit is sent.
    logic parity_q, parity_d;

    always_comb begin
        parity_d = parity_q;
        if ((state_q == IDLE) && tx_start_i) begin
            parity_d = even_parity(PARITY_MAX_BITS'(tx_data_i));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!n_rst_i) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    // Next-state logic. Outputs are decoded from the next state so that the
    // registered line changes on the same edge as the state itself.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (tx_start_i) begin
                    state_d = START;
                    shreg_d = tx_data_i;
                end
            end
            START: begin
                if (w_bit_tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (w_bit_tick) begin
                    shreg_d = shreg_q >> 1;
                    if (w_last_bit) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (w_bit_tick) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (w_bit_tick) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case (state_d)
            START:   serial_d = 1'b0;
            DATA:    serial_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  serial_d = parity_q;
`endif
            default: serial_d = 1'b1;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (!n_rst_i) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            serial_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            serial_q <= serial_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign serial_out_o = serial_q;
    assign tx_busy_o    = busy_q;
    assign tx_done_o    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module  : tb_uart_tx
//  Purpose : Self-checking bench for uart_tx (CLKS_PER_BIT=10, DATA_BITS=8).
//            Expected frames are queued when a byte is offered; a line
//            monitor decodes frames from serial_out at mid-bit.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_uart_tx;

    localparam int CPB = 10;
    localparam int DB  = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NB  = DB + 3;
`else
    localparam int NB  = DB + 2;
`endif

    logic          clk = 1'b0;
    logic          n_rst;
    logic          tx_start;
    logic [DB-1:0] tx_data;
    logic          tx_busy;
    logic          tx_done;
    logic          serial;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DB)
    ) dut (
        .clk_i        (clk),
        .n_rst_i      (n_rst),
        .tx_data_i    (tx_data),
        .tx_start_i   (tx_start),
        .tx_busy_o    (tx_busy),
        .tx_done_o    (tx_done),
        .serial_out_o (serial)
    );

    typedef struct {
        logic [NB-1:0] bits;
        int            start_cyc;
    } frame_t;

    frame_t        rx_q[$];
    logic [NB-1:0] exp_q[$];
    int            checks = 0;
    int            errors = 0;

    // Reference frame: start 0, data LSB first, [even parity], stop 1.
    function automatic logic [NB-1:0] frame_of(input logic [DB-1:0] d);
        logic [NB-1:0] f;
        f        = '0;
        f[0]     = 1'b0;
        f[DB:1]  = d;
`ifdef UART_TX_PARITY_EN
        f[DB+1]  = ^d;
`endif
        f[NB-1]  = 1'b1;
        return f;
    endfunction

    // Line monitor: detect the start edge, sample each bit mid-period,
    // abandon any frame cut short by reset.
    bit            mon_active = 1'b0;
    int            mon_cnt;
    int            mon_cyc;
    logic [NB-1:0] mon_bits;

    initial begin : monitor
        frame_t fr;
        forever begin
            @(negedge clk);
            if (n_rst !== 1'b1) begin
                mon_active = 1'b0;
            end else begin
                if (!mon_active && serial === 1'b0) begin
                    mon_active = 1'b1;
                    mon_cnt    = 0;
                    mon_bits   = '0;
                    mon_cyc    = cyc;
                end
                if (mon_active) begin
                    if ((mon_cnt % CPB) == CPB / 2) begin
                        mon_bits[mon_cnt / CPB] = serial;
                        if ((mon_cnt / CPB) == NB - 1) begin
                            fr.bits      = mon_bits;
                            fr.start_cyc = mon_cyc;
                            rx_q.push_back(fr);
                            mon_active   = 1'b0;
                        end
                    end
                    mon_cnt++;
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    // Offer one byte once the transmitter is idle; returns on the negedge
    // right after the acceptance edge.
    task automatic send_frame(input logic [DB-1:0] d);
        int n;
        @(negedge clk);
        n = 0;
        while (tx_busy !== 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL send_idle_wait: tx_busy=%b required 0", tx_busy);
        end
        tx_data  = d;
        tx_start = 1'b1;
        exp_q.push_back(frame_of(d));
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        int t;
        t = 0;
        while (rx_q.size() < n && t < 400) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic test_reset();
        n_rst    = 1'b0;
        tx_start = 1'b1;
        tx_data  = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks += 3;
            if (serial !== 1'b1) begin
                errors++;
                $display("FAIL reset_serial[%0d]: got %b required 1", i, serial);
            end
            if (tx_busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_busy[%0d]: got %b required 0", i, tx_busy);
            end
            if (tx_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_done[%0d]: got %b required 0", i, tx_done);
            end
        end
        tx_start = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        repeat (30) @(negedge clk);
        checks++;
        if (rx_q.size() != 0 || serial !== 1'b1) begin
            errors++;
            $display("FAIL reset_nothing_sent: frames=%0d serial=%b required 0 frames, serial 1",
                     rx_q.size(), serial);
        end
    endtask

    task automatic test_basic();
        int busy_cnt, done_cnt, done_k, low_run;
        bit low_open;
        frame_t f;
        logic [NB-1:0] e;
        send_frame(8'hA5);
        checks += 2;
        if (serial !== 1'b0) begin
            errors++;
            $display("FAIL basic_start_latency: serial=%b required 0", serial);
        end
        if (tx_busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy_rise: tx_busy=%b required 1", tx_busy);
        end
        busy_cnt = 1; done_cnt = 0; done_k = 0; low_run = 1; low_open = 1'b1;
        for (int k = 2; k <= NB * CPB + 20; k++) begin
            @(negedge clk);
            if (tx_busy === 1'b1) busy_cnt++;
            if (tx_done === 1'b1) begin
                done_cnt++;
                done_k = k;
            end
            if (low_open) begin
                if (serial === 1'b0) low_run++;
                else low_open = 1'b0;
            end
        end
        checks += 4;
        if (busy_cnt != NB * CPB) begin
            errors++;
            $display("FAIL basic_busy_len: got %0d cycles required %0d", busy_cnt, NB * CPB);
        end
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL basic_done_count: got %0d pulses required 1", done_cnt);
        end
        if (done_k != NB * CPB + 1) begin
            errors++;
            $display("FAIL basic_done_time: got cycle %0d required %0d", done_k, NB * CPB + 1);
        end
        if (low_run != CPB) begin
            errors++;
            $display("FAIL basic_start_len: got %0d cycles required %0d", low_run, CPB);
        end
        checks++;
        if (rx_q.size() == 1 && exp_q.size() == 1) begin
            f = rx_q.pop_front();
            e = exp_q.pop_front();
            if (f.bits !== e) begin
                errors++;
                $display("FAIL basic_frame: got %b required %b", f.bits, e);
            end
        end else begin
            errors++;
            $display("FAIL basic_frame_count: got %0d frames required 1", rx_q.size());
        end
    endtask

    task automatic test_busy_ignore();
        frame_t f;
        logic [NB-1:0] e;
        send_frame(8'h3C);
        repeat (38) @(negedge clk);
        tx_data  = 8'hFF;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        wait_frames(1);
        repeat (150) @(negedge clk);
        checks += 2;
        if (rx_q.size() == 1 && exp_q.size() == 1) begin
            f = rx_q.pop_front();
            e = exp_q.pop_front();
            if (f.bits !== e) begin
                errors++;
                $display("FAIL busy_frame: got %b required %b", f.bits, e);
            end
        end else begin
            errors++;
            $display("FAIL busy_frame_count: got %0d frames required 1", rx_q.size());
            rx_q.delete();
            exp_q.delete();
        end
        if (tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_no_second: tx_busy=%b required 0", tx_busy);
        end
    endtask

    task automatic test_back_to_back();
        int t;
        frame_t f1, f2;
        logic [NB-1:0] e1, e2;
        @(negedge clk);
        t = 0;
        while (tx_busy !== 1'b0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        tx_data  = 8'h00;
        tx_start = 1'b1;
        exp_q.push_back(frame_of(8'h00));
        @(negedge clk);
        // Changing the payload mid-frame must only affect the next frame.
        tx_data = 8'hFF;
        exp_q.push_back(frame_of(8'hFF));
        t = 0;
        while (tx_done !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (tx_done !== 1'b1 || tx_busy !== 1'b0 || serial !== 1'b1) begin
            errors++;
            $display("FAIL b2b_gap_cycle: done=%b busy=%b serial=%b required 1 0 1",
                     tx_done, tx_busy, serial);
        end
        @(negedge clk);
        tx_start = 1'b0;
        checks++;
        if (serial !== 1'b0 || tx_busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_restart: serial=%b busy=%b required 0 1", serial, tx_busy);
        end
        wait_frames(2);
        checks += 3;
        if (rx_q.size() == 2 && exp_q.size() == 2) begin
            f1 = rx_q.pop_front();
            f2 = rx_q.pop_front();
            e1 = exp_q.pop_front();
            e2 = exp_q.pop_front();
            if (f1.bits !== e1) begin
                errors++;
                $display("FAIL b2b_frame1: got %b required %b", f1.bits, e1);
            end
            if (f2.bits !== e2) begin
                errors++;
                $display("FAIL b2b_frame2: got %b required %b", f2.bits, e2);
            end
            if (f2.start_cyc - f1.start_cyc != NB * CPB + 1) begin
                errors++;
                $display("FAIL b2b_period: got %0d cycles required %0d",
                         f2.start_cyc - f1.start_cyc, NB * CPB + 1);
            end
        end else begin
            errors += 3;
            $display("FAIL b2b_frame_count: got %0d frames required 2", rx_q.size());
            rx_q.delete();
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        frame_t f;
        logic [NB-1:0] e;
        send_frame(8'hC3);
        repeat (44) @(negedge clk);     // inside data bit 3
        n_rst = 1'b0;
        @(negedge clk);
        checks += 3;
        if (serial !== 1'b1) begin
            errors++;
            $display("FAIL midrst_serial: got %b required 1", serial);
        end
        if (tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_busy: got %b required 0", tx_busy);
        end
        if (tx_done !== 1'b0) begin
            errors++;
            $display("FAIL midrst_done: got %b required 0", tx_done);
        end
        n_rst = 1'b1;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        repeat (30) @(negedge clk);
        checks++;
        if (rx_q.size() != 0) begin
            errors++;
            $display("FAIL midrst_aborted: got %0d frames required 0", rx_q.size());
            rx_q.delete();
        end
        send_frame(8'h96);
        wait_frames(1);
        checks++;
        if (rx_q.size() == 1 && exp_q.size() == 1) begin
            f = rx_q.pop_front();
            e = exp_q.pop_front();
            if (f.bits !== e) begin
                errors++;
                $display("FAIL midrst_next_frame: got %b required %b", f.bits, e);
            end
        end else begin
            errors++;
            $display("FAIL midrst_next_count: got %0d frames required 1", rx_q.size());
            rx_q.delete();
            exp_q.delete();
        end
    endtask

    task automatic test_patterns();
        logic [DB-1:0] pat [3];
        logic          par [3];
        frame_t f;
        logic [NB-1:0] e;
        pat[0] = 8'h01; par[0] = 1'b1;
        pat[1] = 8'h03; par[1] = 1'b0;
        pat[2] = 8'h80; par[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_frame(pat[i]);
            wait_frames(1);
            checks++;
            if (rx_q.size() == 1 && exp_q.size() == 1) begin
                f = rx_q.pop_front();
                e = exp_q.pop_front();
                if (f.bits !== e) begin
                    errors++;
                    $display("FAIL pattern_%02h: got %b required %b", pat[i], f.bits, e);
                end
`ifdef UART_TX_PARITY_EN
                checks++;
                if (f.bits[DB+1] !== par[i]) begin
                    errors++;
                    $display("FAIL parity_%02h: got %b required %b", pat[i], f.bits[DB+1], par[i]);
                end
`else
                if (par[i] === 1'bx) $display("parity table entry %0d undefined", i);
`endif
            end else begin
                errors++;
                $display("FAIL pattern_count_%02h: got %0d frames required 1", pat[i], rx_q.size());
                rx_q.delete();
                exp_q.delete();
            end
        end
    endtask

    initial begin : main
        n_rst    = 1'b0;
        tx_start = 1'b0;
        tx_data  = '0;
        test_reset();
        test_basic();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_patterns();
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
